// File: rtl/sequenciador_passos_if.sv
// Step-count inputs from the ripple divider and the actuator/display outputs.
// master drives the divider bits; slave is the sequencer that consumes them.
interface sequenciador_passos_if;
   logic       bit0;
   logic       bit1;
   logic       bit2;
   logic [2:0] passo;
   logic       passo_pulso;
   logic       motor;
   logic       led;
   logic       buzzer;
   logic [3:0] voltas;
   logic       erro;
   logic [6:0] segmentos;

   modport master (
      output bit0, bit1, bit2,
      input  passo, passo_pulso, motor, led, buzzer, voltas, erro, segmentos
   );

   modport slave (
      input  bit0, bit1, bit2,
      output passo, passo_pulso, motor, led, buzzer, voltas, erro, segmentos
   );
endinterface

// File: rtl/sequenciador_passos.sv
// Resynchronizes and debounces the ripple step count, checks +1 mod 8 sequencing,
// and drives actuators, lap counter and 7-segment display from the accepted step.
module sequenciador_passos #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic                 clock_entrada,
   input  logic                 botao,
   sequenciador_passos_if.slave io
);
   typedef enum logic [1:0] {INICIO, ATIVO, FALHA} estado_t;

   localparam logic [3:0] CNT_MIN = 4'(STABLE_CYCLES - 1);

   estado_t    estado, estado_next;
   logic [2:0] s1, s2, s_prev;
   logic [3:0] cnt;
   logic [2:0] passo, passo_next, esperado;
   logic       aceita, volta;
   logic       passo_pulso, motor, led, buzzer;
   logic       motor_next, led_next, buzzer_next;
   logic [3:0] voltas;
   logic [6:0] segmentos, seg_next;

   // s_prev holds last cycle's synchronized value so cnt measures how long s2 has been steady
   always_ff @(posedge clock_entrada or posedge botao) begin
      if (botao) begin
         s1     <= '0;
         s2     <= '0;
         s_prev <= '0;
         cnt    <= '0;
      end else begin
         s1     <= {io.bit2, io.bit1, io.bit0};
         s2     <= s1;
         s_prev <= s2;
         if (s2 != s_prev)
            cnt <= '0;
         else if (cnt != 4'hF)
            cnt <= cnt + 4'd1;
      end
   end

   assign esperado = passo + 3'd1;
   assign aceita   = (s2 == s_prev) && (cnt >= CNT_MIN) && (s2 != passo);

   always_ff @(posedge clock_entrada or posedge botao) begin
      if (botao)
         estado <= INICIO;
      else
         estado <= estado_next;
   end

   always_comb begin
      estado_next = estado;
      passo_next  = passo;
      volta       = 1'b0;
      if (aceita) begin
         passo_next = s2;
         case (estado)
            INICIO: estado_next = (s2 == 3'd1) ? ATIVO : FALHA;
            ATIVO: begin
               if (s2 != esperado)
                  estado_next = FALHA;
               else
                  volta = (passo == 3'd7);
            end
            default: estado_next = FALHA;
         endcase
      end
   end

   always_comb begin
      motor_next  = 1'b0;
      led_next    = 1'b0;
      buzzer_next = 1'b0;
      seg_next    = 7'b1000000;
      if (estado_next == ATIVO) begin
         motor_next  = (passo_next >= 3'd1) && (passo_next <= 3'd3);
         led_next    = ~passo_next[0];
         buzzer_next = (passo_next == 3'd7);
      end
      case (passo_next)
         3'd0: seg_next = 7'b1000000;
         3'd1: seg_next = 7'b1111001;
         3'd2: seg_next = 7'b0100100;
         3'd3: seg_next = 7'b0110000;
         3'd4: seg_next = 7'b0011001;
         3'd5: seg_next = 7'b0010010;
         3'd6: seg_next = 7'b0000010;
         3'd7: seg_next = 7'b1111000;
         default: seg_next = 7'b1000000;
      endcase
   end

   always_ff @(posedge clock_entrada or posedge botao) begin
      if (botao) begin
         passo       <= '0;
         passo_pulso <= 1'b0;
         motor       <= 1'b0;
         led         <= 1'b0;
         buzzer      <= 1'b0;
         voltas      <= '0;
         segmentos   <= 7'b1000000;
      end else begin
         passo       <= passo_next;
         passo_pulso <= aceita;
         motor       <= motor_next;
         led         <= led_next;
         buzzer      <= buzzer_next;
         segmentos   <= seg_next;
         if (volta && (voltas != 4'd15))
            voltas <= voltas + 4'd1;
      end
   end

   assign io.passo       = passo;
   assign io.passo_pulso = passo_pulso;
   assign io.motor       = motor;
   assign io.led         = led;
   assign io.buzzer      = buzzer;
   assign io.voltas      = voltas;
   assign io.erro        = (estado == FALHA);
   assign io.segmentos   = segmentos;
endmodule
